// File: rtl/controle_banco_if.sv
// Request, operand-return and bank-port bundle for controle_banco.
// slave is the sequencer's view; master is the requester plus bank side.
interface controle_banco_if;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic          rd_req;
   logic [AW-1:0] rs_addr;
   logic [AW-1:0] rt_addr;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          rd_valid;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic [AW-1:0] bank_address;
   logic          bank_enable_write;
   logic          bank_enable_read;
   logic [DW-1:0] bank_in_data;
   logic [DW-1:0] bank_out_data;

   modport slave (
      input  rd_req, rs_addr, rt_addr, wr_req, wr_addr, wr_data, bank_out_data,
      output busy, rd_valid, op_a, op_b,
             bank_address, bank_enable_write, bank_enable_read, bank_in_data
   );

   modport master (
      output rd_req, rs_addr, rt_addr, wr_req, wr_addr, wr_data, bank_out_data,
      input  busy, rd_valid, op_a, op_b,
             bank_address, bank_enable_write, bank_enable_read, bank_in_data
   );
endinterface

// File: rtl/controle_banco.sv
// Serializes write-back and two-operand reads onto the single-port register bank,
// enforcing $zero and write-before-read ordering.
module controle_banco (
   input  logic             clock,
   input  logic             reset,
   controle_banco_if.slave  bus
);
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WRITE  = 3'd1,
      READ_A = 3'd2,
      READ_B = 3'd3,
      CAP    = 3'd4
   } state_t;

   state_t        state;
   state_t        state_n;

   logic          rd_pend;
   logic          rd_pend_n;
   logic [AW-1:0] rs_q;
   logic [AW-1:0] rs_n;
   logic [AW-1:0] rt_q;
   logic [AW-1:0] rt_n;
   logic [AW-1:0] wa_q;
   logic [AW-1:0] wa_n;
   logic [DW-1:0] wd_q;
   logic [DW-1:0] wd_n;
   logic [DW-1:0] tmp_q;
   logic [DW-1:0] tmp_n;

   logic [DW-1:0] op_a_q;
   logic [DW-1:0] op_a_n;
   logic [DW-1:0] op_b_q;
   logic [DW-1:0] op_b_n;
   logic          valid_q;
   logic          valid_n;
   logic          busy_q;
   logic          busy_n;

   logic [AW-1:0] baddr_q;
   logic [AW-1:0] baddr_n;
   logic          bwe_q;
   logic          bwe_n;
   logic          bre_q;
   logic          bre_n;
   logic [DW-1:0] bdin_q;
   logic [DW-1:0] bdin_n;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next state, latches and next-cycle outputs
   always_comb begin
      state_n   = state;
      rd_pend_n = rd_pend;
      rs_n      = rs_q;
      rt_n      = rt_q;
      wa_n      = wa_q;
      wd_n      = wd_q;
      tmp_n     = tmp_q;
      op_a_n    = op_a_q;
      op_b_n    = op_b_q;
      valid_n   = 1'b0;

      case (state)
         IDLE: begin
            if (bus.wr_req && (bus.wr_addr != AW'(0))) begin
               wa_n    = bus.wr_addr;
               wd_n    = bus.wr_data;
               state_n = WRITE;
               if (bus.rd_req) begin
                  rs_n      = bus.rs_addr;
                  rt_n      = bus.rt_addr;
                  rd_pend_n = 1'b1;
               end
            end else if (bus.rd_req) begin
               // A write to r0 is dropped here; any read goes straight on
               rs_n    = bus.rs_addr;
               rt_n    = bus.rt_addr;
               state_n = READ_A;
            end
         end
         WRITE: begin
            if (rd_pend) begin
               rd_pend_n = 1'b0;
               state_n   = READ_A;
            end else begin
               state_n = IDLE;
            end
         end
         READ_A: state_n = READ_B;
         READ_B: begin
            tmp_n   = bus.bank_out_data;
            state_n = CAP;
         end
         CAP: begin
            op_a_n  = (rs_q == AW'(0)) ? DW'(0) : tmp_q;
            op_b_n  = (rt_q == AW'(0)) ? DW'(0) : bus.bank_out_data;
            valid_n = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // Bank port is registered, so it is derived from the state being entered
      busy_n  = (state_n != IDLE);
      baddr_n = AW'(0);
      bwe_n   = 1'b0;
      bre_n   = 1'b0;
      bdin_n  = DW'(0);
      case (state_n)
         WRITE: begin
            baddr_n = wa_n;
            bwe_n   = 1'b1;
            bdin_n  = wd_n;
         end
         READ_A: begin
            baddr_n = rs_n;
            bre_n   = 1'b1;
         end
         READ_B: begin
            baddr_n = rt_n;
            bre_n   = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_pend <= 1'b0;
         rs_q    <= '0;
         rt_q    <= '0;
         wa_q    <= '0;
         wd_q    <= '0;
         tmp_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         baddr_q <= '0;
         bwe_q   <= 1'b0;
         bre_q   <= 1'b0;
         bdin_q  <= '0;
      end else begin
         rd_pend <= rd_pend_n;
         rs_q    <= rs_n;
         rt_q    <= rt_n;
         wa_q    <= wa_n;
         wd_q    <= wd_n;
         tmp_q   <= tmp_n;
         op_a_q  <= op_a_n;
         op_b_q  <= op_b_n;
         valid_q <= valid_n;
         busy_q  <= busy_n;
         baddr_q <= baddr_n;
         bwe_q   <= bwe_n;
         bre_q   <= bre_n;
         bdin_q  <= bdin_n;
      end
   end

   assign bus.busy              = busy_q;
   assign bus.rd_valid          = valid_q;
   assign bus.op_a              = op_a_q;
   assign bus.op_b              = op_b_q;
   assign bus.bank_address      = baddr_q;
   assign bus.bank_enable_write = bwe_q;
   assign bus.bank_enable_read  = bre_q;
   assign bus.bank_in_data      = bdin_q;
endmodule

// File: tb/tb_controle_banco.sv
// Randomized self-checking bench for controle_banco with a behavioural bank and register model.
module tb_controle_banco;
   logic clock = 1'b0;
   logic reset = 1'b1;

   controle_banco_if bus ();

   controle_banco dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Bank: synchronous single port, registered read data, no $zero handling
   logic [31:0] mem [32];
   logic        pre_en   = 1'b0;
   logic [4:0]  pre_addr = '0;
   logic [31:0] pre_data = '0;

   always @(posedge clock) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (bus.bank_enable_write) mem[bus.bank_address] <= bus.bank_in_data;
      if (bus.bank_enable_read && !bus.bank_enable_write)
         bus.bank_out_data <= mem[bus.bank_address];
      else
         bus.bank_out_data <= $urandom();
   end

   // Architectural register model
   logic [31:0] ref_regs [32];
   logic [31:0] last_a = '0;
   logic [31:0] last_b = '0;

   function automatic logic [31:0] rf(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : ref_regs[a];
   endfunction

   // Bus-level protocol checker
   logic saw_w0 = 1'b0;
   always @(negedge clock) begin
      if (!reset) begin
         checks++;
         if (bus.bank_enable_write && bus.bank_enable_read) begin
            failures++;
            $display("FAIL enable_overlap: we=%b re=%b, required never both 1",
                     bus.bank_enable_write, bus.bank_enable_read);
         end
         if (bus.bank_enable_write && bus.bank_address == 5'd0) saw_w0 = 1'b1;
      end
   end

   logic       we_log   [1:8];
   logic       re_log   [1:8];
   logic [4:0] addr_log [1:8];

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      @(negedge clock);
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clock);
      pre_en = 1'b0;
      ref_regs[a] = d;
   endtask

   // Present one request at an IDLE sampling edge, then observe 8 cycles
   task automatic transact(input logic rd, input logic [4:0] rs, input logic [4:0] rt,
                           input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                           output int vcyc, output int nvalid, output int busy_cnt,
                           output logic [31:0] a, output logic [31:0] b,
                           output logic idle_at_valid);
      @(negedge clock);
      bus.rd_req = rd; bus.rs_addr = rs; bus.rt_addr = rt;
      bus.wr_req = wr; bus.wr_addr = wa; bus.wr_data = wd;
      @(posedge clock);
      #1;
      bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      vcyc = 0; nvalid = 0; busy_cnt = 0; a = '0; b = '0; idle_at_valid = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         we_log[c]   = bus.bank_enable_write;
         re_log[c]   = bus.bank_enable_read;
         addr_log[c] = bus.bank_address;
         if (bus.busy) busy_cnt++;
         if (bus.rd_valid) begin
            nvalid++;
            if (vcyc == 0) begin
               vcyc = c; a = bus.op_a; b = bus.op_b; idle_at_valid = !bus.busy;
            end
         end
      end
   endtask

   // Apply the architectural effect of a request to the model
   task automatic model_apply(input logic rd, input logic [4:0] rs, input logic [4:0] rt,
                              input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                              output int exp_lat, output int exp_busy);
      logic wr_eff;
      wr_eff = wr && (wa != 5'd0);
      if (wr_eff) ref_regs[wa] = wd;
      exp_busy = (wr_eff ? 1 : 0) + (rd ? 3 : 0);
      exp_lat  = rd ? (wr_eff ? 5 : 4) : 0;
      if (rd) begin
         last_a = rf(rs);
         last_b = rf(rt);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      bus.rs_addr = '0; bus.rt_addr = '0; bus.wr_addr = '0; bus.wr_data = '0;
      for (int i = 1; i < 32; i++) preload(5'(i), 32'h0);
      preload(5'd0, 32'hBAD0_0BAD);
      ref_regs[0] = 32'h0;
      #1;
      checks += 4;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.rd_valid); end
      if (bus.op_a !== 32'h0 || bus.op_b !== 32'h0) begin
         failures++; $display("FAIL reset_ops: got %h/%h want 0/0", bus.op_a, bus.op_b);
      end
      if (bus.bank_address !== 5'd0 || bus.bank_enable_write !== 1'b0 ||
          bus.bank_enable_read !== 1'b0 || bus.bank_in_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_bank: got addr=%h we=%b re=%b din=%h want all 0", bus.bank_address,
                  bus.bank_enable_write, bus.bank_enable_read, bus.bank_in_data);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_write_then_read;
      int v, n, bc, el, eb; logic [31:0] a, b; logic idl;
      transact(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h0000_0005, v, n, bc, a, b, idl);
      model_apply(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h0000_0005, el, eb);
      checks += 2;
      if (bc != eb) begin failures++; $display("FAIL wr_only_busy: got %0d cycles want %0d", bc, eb); end
      if (n != 0) begin failures++; $display("FAIL wr_only_valid: got %0d pulses want 0", n); end
      transact(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0, v, n, bc, a, b, idl);
      model_apply(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0, el, eb);
      checks += 5;
      if (v != 4) begin failures++; $display("FAIL rd_latency: got cycle %0d want 4", v); end
      if (bc != 3) begin failures++; $display("FAIL rd_busy: got %0d cycles want 3", bc); end
      if (!idl) begin failures++; $display("FAIL rd_valid_idle: busy at valid got 1 want 0"); end
      if (n != 1) begin failures++; $display("FAIL rd_pulses: got %0d want 1", n); end
      if (a !== last_a || b !== last_b) begin
         failures++; $display("FAIL rd_r3: got %h/%h want %h/%h", a, b, last_a, last_b);
      end
   endtask

   task automatic test_simultaneous;
      int v, n, bc, el, eb; logic [31:0] a, b; logic idl;
      preload(5'd2, 32'h0000_0011);
      transact(1'b1, 5'd7, 5'd2, 1'b1, 5'd7, 32'hDEAD_BEEF, v, n, bc, a, b, idl);
      model_apply(1'b1, 5'd7, 5'd2, 1'b1, 5'd7, 32'hDEAD_BEEF, el, eb);
      checks += 4;
      if (v != 5) begin failures++; $display("FAIL rw_latency: got cycle %0d want 5", v); end
      if (!(we_log[1] && addr_log[1] == 5'd7)) begin
         failures++; $display("FAIL rw_write_first: got we=%b addr=%0d want 1/7", we_log[1], addr_log[1]);
      end
      if (!(re_log[2] && addr_log[2] == 5'd7)) begin
         failures++; $display("FAIL rw_read_a: got re=%b addr=%0d want 1/7", re_log[2], addr_log[2]);
      end
      if (a !== 32'hDEAD_BEEF || b !== 32'h0000_0011) begin
         failures++; $display("FAIL rw_ops: got %h/%h want deadbeef/00000011", a, b);
      end
   endtask

   task automatic test_zero;
      int v, n, bc, el, eb; logic [31:0] a, b; logic idl;
      saw_w0 = 1'b0;
      transact(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, v, n, bc, a, b, idl);
      model_apply(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, el, eb);
      checks += 2;
      if (saw_w0) begin failures++; $display("FAIL zero_write: got bank write to r0 want none"); end
      if (bc != 0) begin failures++; $display("FAIL zero_busy: got %0d cycles want 0", bc); end
      transact(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, v, n, bc, a, b, idl);
      checks += 2;
      if (a !== 32'h0 || b !== 32'h0) begin failures++; $display("FAIL zero_read: got %h/%h want 0/0", a, b); end
      if (v != 4) begin failures++; $display("FAIL zero_latency: got %0d want 4", v); end
      transact(1'b1, 5'd7, 5'd0, 1'b1, 5'd0, 32'h1234_5678, v, n, bc, a, b, idl);
      model_apply(1'b1, 5'd7, 5'd0, 1'b1, 5'd0, 32'h1234_5678, el, eb);
      checks += 2;
      if (v != el) begin failures++; $display("FAIL zero_rw_latency: got %0d want %0d", v, el); end
      if (a !== last_a || b !== last_b) begin
         failures++; $display("FAIL zero_rw_ops: got %h/%h want %h/%h", a, b, last_a, last_b);
      end
   endtask

   task automatic test_ignore_busy;
      int v = 0, n = 0; logic [31:0] a = '0, b = '0;
      @(negedge clock);
      bus.rd_req = 1'b1; bus.rs_addr = 5'd7; bus.rt_addr = 5'd3; bus.wr_req = 1'b0;
      @(posedge clock);
      #1;
      bus.rs_addr = 5'd2; bus.rt_addr = 5'd0; bus.wr_req = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hAAAA_5555;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         if (c == 3) begin bus.rd_req = 1'b0; bus.wr_req = 1'b0; end
         if (bus.rd_valid) begin
            n++;
            if (v == 0) begin v = c; a = bus.op_a; b = bus.op_b; end
         end
      end
      last_a = rf(5'd7); last_b = rf(5'd3);
      checks += 3;
      if (n != 1) begin failures++; $display("FAIL ignore_pulses: got %0d want 1", n); end
      if (v != 4) begin failures++; $display("FAIL ignore_latency: got %0d want 4", v); end
      if (a !== last_a || b !== last_b) begin
         failures++; $display("FAIL ignore_ops: got %h/%h want %h/%h", a, b, last_a, last_b);
      end
   endtask

   task automatic test_reset_mid;
      int n = 0, v, bc, el, eb; logic [31:0] a, b; logic idl;
      // Abort during READ_B
      @(negedge clock);
      bus.rd_req = 1'b1; bus.rs_addr = 5'd3; bus.rt_addr = 5'd7;
      @(posedge clock);
      #1 bus.rd_req = 1'b0;
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      checks += 3;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
      if (bus.op_a !== 32'h0 || bus.op_b !== 32'h0) begin
         failures++; $display("FAIL midreset_ops: got %h/%h want 0/0", bus.op_a, bus.op_b);
      end
      if (bus.bank_address !== 5'd0 || bus.bank_enable_write !== 1'b0 ||
          bus.bank_enable_read !== 1'b0 || bus.bank_in_data !== 32'h0) begin
         failures++; $display("FAIL midreset_bank: got addr=%h we=%b re=%b din=%h want all 0", bus.bank_address,
                              bus.bank_enable_write, bus.bank_enable_read, bus.bank_in_data);
      end
      last_a = '0; last_b = '0;
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (bus.rd_valid) n++;
      end
      checks++;
      if (n != 0) begin failures++; $display("FAIL midreset_valid: got %0d pulses want 0", n); end
      // Abort during WRITE: r9 must keep its old value
      @(negedge clock);
      bus.wr_req = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'hCAFE_F00D;
      @(posedge clock);
      #1 bus.wr_req = 1'b0;
      #2 reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      transact(1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0, v, n, bc, a, b, idl);
      model_apply(1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0, el, eb);
      checks++;
      if (a !== last_a || b !== last_b) begin
         failures++; $display("FAIL cut_write: got %h/%h want %h/%h", a, b, last_a, last_b);
      end
   endtask

   task automatic test_random;
      int v, n, bc, el, eb; logic [31:0] a, b; logic idl;
      logic rd, wr; logic [4:0] rs, rt, wa; logic [31:0] wd;
      for (int i = 0; i < 40; i++) begin
         rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
         if (!rd && !wr) rd = 1'b1;
         rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
         wa = (i % 4 == 0) ? rs : 5'($urandom_range(0, 7));
         wd = $urandom();
         transact(rd, rs, rt, wr, wa, wd, v, n, bc, a, b, idl);
         model_apply(rd, rs, rt, wr, wa, wd, el, eb);
         checks += 4;
         if (v != el) begin failures++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, v, el); end
         if (bc != eb) begin failures++; $display("FAIL rnd%0d_busy: got %0d want %0d", i, bc, eb); end
         if (n != (rd ? 1 : 0)) begin failures++; $display("FAIL rnd%0d_pulses: got %0d want %0d", i, n, rd); end
         if (rd) begin
            if (a !== last_a || b !== last_b) begin
               failures++; $display("FAIL rnd%0d_ops: got %h/%h want %h/%h", i, a, b, last_a, last_b);
            end
         end else if (bus.op_a !== last_a || bus.op_b !== last_b) begin
            failures++; $display("FAIL rnd%0d_hold: got %h/%h want %h/%h", i, bus.op_a, bus.op_b, last_a, last_b);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [4:0] qa[$];
      logic [4:0] qb[$];
      logic [4:0] ea, eb;
      int got = 0, last_v = -1;
      for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
         @(negedge clock);
         if (bus.rd_valid) begin
            checks++;
            if (qa.size() == 0) begin
               failures++; $display("FAIL b2b_spurious: got rd_valid want none outstanding");
            end else begin
               ea = qa.pop_front(); eb = qb.pop_front();
               if (bus.op_a !== rf(ea) || bus.op_b !== rf(eb)) begin
                  failures++; $display("FAIL b2b_ops: got %h/%h want %h/%h", bus.op_a, bus.op_b, rf(ea), rf(eb));
               end
            end
            if (last_v >= 0) begin
               checks++;
               if (cyc - last_v != 4) begin failures++; $display("FAIL b2b_interval: got %0d want 4", cyc - last_v); end
            end
            last_v = cyc;
            got++;
         end
         if (!bus.busy) begin
            if (got + qa.size() < 5) begin
               bus.rd_req = 1'b1;
               bus.rs_addr = 5'($urandom_range(0, 9)); bus.rt_addr = 5'($urandom_range(0, 9));
               qa.push_back(bus.rs_addr); qb.push_back(bus.rt_addr);
            end else begin
               bus.rd_req = 1'b0;
            end
         end
      end
      bus.rd_req = 1'b0;
      checks++;
      if (got != 5) begin failures++; $display("FAIL b2b_timeout: got %0d results want 5", got); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
      test_reset;
      test_write_then_read;
      test_simultaneous;
      test_zero;
      test_ignore_busy;
      test_reset_mid;
      test_random;
      test_back_to_back;
      repeat (4) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
